// File: rtl/register_file_mp.sv
// Multi-port register file: READ_PORTS combinational reads, two prioritised write ports,
// optional write-to-read bypass, optional hardwired-zero r0 and a sequenced bulk-clear engine.
module register_file_mp #(
  parameter int WORD_LENGTH = 8,
  parameter int REG_AMOUNT  = 8,
  parameter int READ_PORTS  = 3,
  parameter int ZERO_REG    = 0,
  parameter int BYPASS      = 1,
  localparam int AW         = $clog2(REG_AMOUNT)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wrEn0,
  input  logic [AW-1:0]                     addrWrite0,
  input  logic [WORD_LENGTH-1:0]            dataIn0,
  input  logic                              wrEn1,
  input  logic [AW-1:0]                     addrWrite1,
  input  logic [WORD_LENGTH-1:0]            dataIn1,
  input  logic [READ_PORTS*AW-1:0]          addrRead,
  output logic [READ_PORTS*WORD_LENGTH-1:0] dataOut,
  input  logic                              clrReq,
  output logic                              clrBusy,
  output logic                              clrDone,
  output logic [1:0]                        dbgState
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(REG_AMOUNT - 1);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [AW-1:0]          r_idx;
  logic [WORD_LENGTH-1:0] r_mem [REG_AMOUNT];
  logic                   w_idle;
  logic                   w_acc0;
  logic                   w_acc1;

  // Clear handshake: clrReq is a level sampled only in IDLE; clrBusy covers CLEAR+DONE,
  // and clrDone is a single-cycle pulse in DONE. Writes are only accepted while idle.
  assign w_idle = (r_state == ST_IDLE);
  assign w_acc0 = w_idle && wrEn0 && !((ZERO_REG != 0) && (addrWrite0 == '0));
  assign w_acc1 = w_idle && wrEn1 && !((ZERO_REG != 0) && (addrWrite1 == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (clrReq) w_next_state = ST_CLEAR;
      ST_CLEAR: if (r_idx == LAST_IDX) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    clrBusy  = (r_state != ST_IDLE);
    clrDone  = (r_state == ST_DONE);
    dbgState = r_state;
  end

  // The index wraps to 0 naturally on the final clear step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_idx <= '0;
    else if (r_state == ST_IDLE && clrReq)  r_idx <= '0;
    else if (r_state == ST_CLEAR)           r_idx <= r_idx + 1'b1;
  end

  // Port 1 is assigned last so it wins when both ports hit the same address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_AMOUNT; i++) r_mem[i] <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_mem[r_idx] <= '0;
    end else begin
      if (w_acc0) r_mem[addrWrite0] <= dataIn0;
      if (w_acc1) r_mem[addrWrite1] <= dataIn1;
    end
  end

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
    logic [AW-1:0]          w_ra;
    logic [WORD_LENGTH-1:0] w_rd;

    assign w_ra = addrRead[k*AW +: AW];

    always_comb begin
      w_rd = r_mem[w_ra];
      if ((ZERO_REG != 0) && (w_ra == '0)) w_rd = '0;
      if (BYPASS != 0) begin
        if (w_acc1 && (addrWrite1 == w_ra))      w_rd = dataIn1;
        else if (w_acc0 && (addrWrite0 == w_ra)) w_rd = dataIn0;
      end
    end

    assign dataOut[k*WORD_LENGTH +: WORD_LENGTH] = w_rd;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a default instance (bypass, no zero reg) and an alternate
// instance (zero reg, no bypass) share stimulus; a bench-side model feeds a read scoreboard.
module tb_register_file_mp;

  localparam int W  = 8;
  localparam int R  = 8;
  localparam int AW = 3;
  localparam int RP = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             wrEn0, wrEn1;
  logic [AW-1:0]    addrWrite0, addrWrite1;
  logic [W-1:0]     dataIn0, dataIn1;
  logic [RP*AW-1:0] addrRead;
  logic             clrReq;
  logic [RP*W-1:0]  dout_a, dout_b;
  logic             busy_a, done_a, busy_b, done_b;
  logic [1:0]       st_a, st_b;

  register_file_mp #(.WORD_LENGTH(W), .REG_AMOUNT(R), .READ_PORTS(RP), .ZERO_REG(0), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst),
    .wrEn0(wrEn0), .addrWrite0(addrWrite0), .dataIn0(dataIn0),
    .wrEn1(wrEn1), .addrWrite1(addrWrite1), .dataIn1(dataIn1),
    .addrRead(addrRead), .dataOut(dout_a),
    .clrReq(clrReq), .clrBusy(busy_a), .clrDone(done_a), .dbgState(st_a)
  );

  register_file_mp #(.WORD_LENGTH(W), .REG_AMOUNT(R), .READ_PORTS(RP), .ZERO_REG(1), .BYPASS(0)) u_alt (
    .clk(clk), .rst(rst),
    .wrEn0(wrEn0), .addrWrite0(addrWrite0), .dataIn0(dataIn0),
    .wrEn1(wrEn1), .addrWrite1(addrWrite1), .dataIn1(dataIn1),
    .addrRead(addrRead), .dataOut(dout_b),
    .clrReq(clrReq), .clrBusy(busy_b), .clrDone(done_b), .dbgState(st_b)
  );

  // ---------------- model / scoreboard ----------------
  logic [W-1:0] m_a [R];
  logic [W-1:0] m_b [R];
  bit           m_idle;
  logic [W-1:0] exp_q [$];
  string        tag_q [$];
  int           checks   = 0;
  int           failures = 0;
  int           busy_cnt, done_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < R; i++) begin
      m_a[i] = '0;
      m_b[i] = '0;
    end
    m_idle = 1'b1;
  endtask

  function automatic logic [W-1:0] exp_a(input logic [AW-1:0] a);
    if (m_idle && wrEn1 && addrWrite1 == a) return dataIn1;
    if (m_idle && wrEn0 && addrWrite0 == a) return dataIn0;
    return m_a[a];
  endfunction

  function automatic logic [W-1:0] exp_b(input logic [AW-1:0] a);
    if (a == '0) return '0;
    return m_b[a];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    wrEn0 = 1'b0; wrEn1 = 1'b0;
    addrWrite0 = '0; addrWrite1 = '0;
    dataIn0 = '0; dataIn1 = '0;
    clrReq = 1'b0;
  endtask

  task automatic set_wr(input logic e0, input int a0, input int d0,
                        input logic e1, input int a1, input int d1);
    wrEn0 = e0; addrWrite0 = AW'(a0); dataIn0 = W'(d0);
    wrEn1 = e1; addrWrite1 = AW'(a1); dataIn1 = W'(d1);
  endtask

  // Drive read addresses, push expectations, then sample 1ns later and compare.
  task automatic read_check(input int a0, input int a1, input int a2, input string tag);
    logic [AW-1:0] ad;
    addrRead = {AW'(a2), AW'(a1), AW'(a0)};
    for (int k = 0; k < RP; k++) begin
      ad = addrRead[k*AW +: AW];
      exp_q.push_back(exp_a(ad)); tag_q.push_back($sformatf("%s_a%0d", tag, k));
      exp_q.push_back(exp_b(ad)); tag_q.push_back($sformatf("%s_b%0d", tag, k));
    end
    #1;
    for (int k = 0; k < RP; k++) begin
      check(tag_q.pop_front(), dout_a[k*W +: W], exp_q.pop_front());
      check(tag_q.pop_front(), dout_b[k*W +: W], exp_q.pop_front());
    end
  endtask

  // One clock: model takes accepted writes on the edge, then return at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (m_idle && !rst) begin
      if (wrEn0) m_a[addrWrite0] = dataIn0;
      if (wrEn1) m_a[addrWrite1] = dataIn1;
      if (wrEn0 && addrWrite0 != '0) m_b[addrWrite0] = dataIn0;
      if (wrEn1 && addrWrite1 != '0) m_b[addrWrite1] = dataIn1;
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout reached before end of test");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    addrRead = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", {busy_a, busy_b}, 2'b00);
    check("rst_done", {done_a, done_b}, 2'b00);
    check("rst_state", st_a, 2'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < R; i++) begin
      read_check(i, (i + 1) % R, (i + 2) % R, $sformatf("rst_rd%0d", i));
      tick();
    end

    // Dual write to distinct addresses, bypass visible on default instance.
    set_wr(1'b1, 3, 8'hA5, 1'b1, 5, 8'h3C);
    read_check(3, 5, 3, "dual_byp");
    tick();
    idle_inputs();
    read_check(3, 5, 3, "dual_rd");
    tick();

    // Same-address collision: port 1 wins.
    set_wr(1'b1, 2, 8'h11, 1'b1, 2, 8'h22);
    read_check(2, 2, 2, "coll_byp");
    tick();
    idle_inputs();
    read_check(2, 2, 2, "coll_rd");
    tick();

    // Write to reg 0: stored by default instance, ignored by zero-reg instance.
    set_wr(1'b1, 0, 8'hFF, 1'b0, 0, 0);
    read_check(0, 0, 0, "zero_byp");
    tick();
    idle_inputs();
    read_check(0, 0, 0, "zero_rd");
    tick();

    // Bypass versus old value on reg 4.
    set_wr(1'b1, 4, 8'h77, 1'b0, 0, 0);
    read_check(4, 4, 0, "byp4");
    tick();
    idle_inputs();
    read_check(4, 4, 0, "byp4_rd");
    tick();

    for (int i = 0; i < 24; i++) begin
      set_wr(1'($urandom_range(0, 1)), $urandom_range(0, R - 1), $urandom_range(0, 255),
             1'($urandom_range(0, 1)), $urandom_range(0, R - 1), $urandom_range(0, 255));
      read_check($urandom_range(0, R - 1), $urandom_range(0, R - 1), $urandom_range(0, R - 1),
                 $sformatf("rnd%0d", i));
      tick();
    end
    idle_inputs();

    // Fill every register with index+0x10.
    for (int i = 0; i < R / 2; i++) begin
      set_wr(1'b1, 2 * i, 2 * i + 16, 1'b1, 2 * i + 1, 2 * i + 17);
      tick();
    end
    idle_inputs();
    read_check(7, 1, 6, "fill_rd");

    // Bulk clear with a blocked write to reg 7 during CLEAR and DONE.
    clrReq = 1'b1;
    tick();
    clrReq = 1'b0;
    m_idle = 1'b0;
    set_wr(1'b1, 7, 8'h99, 1'b0, 0, 0);
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == R + 1) begin
        idle_inputs();
        m_idle = 1'b1;
      end
      read_check(7, c % R, 0, $sformatf("clr%0d", c));
      check($sformatf("clr_busy%0d", c), busy_a, (c <= R) ? 1 : 0);
      check($sformatf("clr_done%0d", c), done_a, (c == R) ? 1 : 0);
      check($sformatf("clr_alt%0d", c), {busy_b, done_b}, {busy_a, done_a});
      busy_cnt += int'(busy_a);
      done_cnt += int'(done_a);
      tick();
      if (c < R) begin
        m_a[c] = '0;
        m_b[c] = '0;
      end
    end
    check("clr_busy_cycles", busy_cnt, R + 1);
    check("clr_done_pulses", done_cnt, 1);
    for (int i = 0; i < R; i++) begin
      read_check(i, i, 7, $sformatf("post_clr%0d", i));
      tick();
    end

    // Reset in the middle of a clear.
    set_wr(1'b1, 1, 8'h55, 1'b1, 6, 8'h66);
    tick();
    idle_inputs();
    clrReq = 1'b1;
    tick();
    clrReq = 1'b0;
    m_idle = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      m_a[c] = '0;
      m_b[c] = '0;
    end
    rst = 1'b1;
    model_reset();
    read_check(1, 6, 5, "midrst");
    check("midrst_busy", {busy_a, busy_b}, 2'b00);
    check("midrst_done", {done_a, done_b}, 2'b00);
    tick();
    rst = 1'b0;
    done_cnt = 0;
    busy_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      done_cnt += int'(done_a) + int'(done_b);
      busy_cnt += int'(busy_a) + int'(busy_b);
      tick();
    end
    check("midrst_no_done", done_cnt, 0);
    check("midrst_no_busy", busy_cnt, 0);
    set_wr(1'b1, 6, 8'h42, 1'b0, 0, 0);
    tick();
    idle_inputs();
    read_check(6, 1, 0, "after_rst_wr");
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file: successor to the 3-read/1-write `register_file`. It adds a configurable read-port count, two write ports with fixed priority, optional write-to-read bypass, optional hardwired-zero register 0, and a sequenced bulk-clear engine with a busy/done handshake. It sits in the datapath as the operand store, feeding combinational read data to execution logic.

## Interface
- `WORD_LENGTH`, 8: bits per register, ≥1.
- `REG_AMOUNT`, 8: number of registers; power of two, ≥2. AW = $clog2(REG_AMOUNT).
- `READ_PORTS`, 3: number of read ports, 1..8.
- `ZERO_REG`, 0: 1 = register 0 always reads 0 and ignores writes.
- `BYPASS`, 1: 1 = same-cycle write data forwarded to matching read ports.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `wrEn0`  in  1  write port 0 enable.
- `addrWrite0`  in  AW  write port 0 address.
- `dataIn0`  in  WORD_LENGTH  write port 0 data.
- `wrEn1`  in  1  write port 1 enable; wins over port 0 on the same address.
- `addrWrite1`  in  AW  write port 1 address.
- `dataIn1`  in  WORD_LENGTH  write port 1 data.
- `addrRead`  in  READ_PORTS*AW  packed read addresses; port k at bits [k*AW +: AW].
- `dataOut`  out  READ_PORTS*WORD_LENGTH  packed combinational read data; port k at [k*WORD_LENGTH +: WORD_LENGTH].
- `clrReq`  in  1  bulk-clear request, sampled on the rising edge.
- `clrBusy`  out  1  clear in progress.
- `clrDone`  out  1  one-cycle pulse when the clear completes.

## Operation
- Reset (asynchronous): all registers 0, FSM in IDLE, `clrBusy`=0, `clrDone`=0. All `dataOut` lanes read 0 once reset takes effect.
- Write acceptance: a write is accepted only when FSM=IDLE, its enable is set, and it is not (ZERO_REG=1 and address=0).
  - Two accepted writes to different addresses: both land on the same edge.
  - Same address: port 1 data is stored and port 0 is dropped.
- Read: `dataOut[k]` = array[`addrRead[k]`], combinational. With ZERO_REG=1 and address 0, it reads 0.
- Bypass (BYPASS=1): if an accepted write targets `addrRead[k]` in the current cycle, `dataOut[k]` shows that write's data (port 1 data if both ports match). BYPASS=0: the old value is shown until after the edge.
- Clear FSM states:
  - IDLE: `clrReq`=1 → CLEAR with index ← 0. Writes presented in the same cycle are still accepted.
  - CLEAR: zero array[index] each cycle and increment the index. All external writes are ignored. `clrReq` is ignored.
  - CLEAR exit: when the index = REG_AMOUNT-1 is zeroed, go to DONE.
  - DONE: `clrDone`=1 for exactly one cycle, then IDLE. Writes are ignored in DONE.
- `clrBusy`=1 in CLEAR and DONE, 0 in IDLE.
- Reads during CLEAR return the current, partially cleared contents. There is no bypass during CLEAR or DONE.
- Index counter is AW bits and wraps to 0 only on exit. It does not affect anything in IDLE.

## Timing
- Write latency: data is visible on reads in the cycle after the accepting edge. With BYPASS=1 it is visible in the same cycle.
- Clear sequence, with `clrReq` sampled at edge E:
  - `clrBusy` rises after E.
  - Registers 0..REG_AMOUNT-1 are zeroed at edges E+1..E+REG_AMOUNT.
  - `clrDone`=1 between edges E+REG_AMOUNT and E+REG_AMOUNT+1.
  - `clrBusy` falls after E+REG_AMOUNT+1.
  - Total busy time: REG_AMOUNT+1 cycles.
- `clrReq` held high continuously: a new clear starts on the first edge sampled in IDLE. Back-to-back clears have one IDLE cycle between them.
- Reset asserted mid-clear: the FSM goes to IDLE immediately, all registers are 0, `clrDone` does not pulse.
- Reset deasserted: writes are accepted on the first rising edge after deassertion.

## Test plan
- Reset, then read every address on all READ_PORTS → all lanes 0, `clrBusy`=0, `clrDone`=0.
- Write 0xA5 to reg 3 via port 0 and 0x3C to reg 5 via port 1 in one cycle; next cycle read 3/5/3 → 0xA5/0x3C/0xA5.
- Both ports write reg 2 (port 0 = 0x11, port 1 = 0x22); read reg 2 → 0x22.
- ZERO_REG=1:
  - Write 0xFF to reg 0 → reads 0.
  - BYPASS=1: write 0x77 to reg 4 while reading reg 4 in the same cycle → 0x77 before the edge. With BYPASS=0, the old value is shown before the edge.
- Fill all registers with index+0x10, pulse `clrReq`, and attempt a write of 0x99 to reg 7 during CLEAR:
  - `clrBusy` is high for 9 cycles (REG_AMOUNT=8).
  - Exactly one `clrDone` pulse.
  - All registers read 0 afterwards; reg 7 is not 0x99.
- Start a clear, assert `rst` after 3 cycles → outputs 0 immediately, no `clrDone` pulse, a write after release is accepted normally.
